// File: rtl/psum_out_fifo.sv
// Output buffer behind the PE datapath: captures finished partial sums, back-pressures
// the datapath when full, and drains first-word-fall-through over valid/ready.
module psum_out_fifo #(
   parameter int DATA_WIDTH = 33,
   parameter int DEPTH      = 8,
   parameter int ADDR_LEN   = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  outbuf_write,
   input  logic [DATA_WIDTH-1:0] din,
   output logic                  outbuf_full,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] dout,
   output logic [ADDR_LEN:0]     count,
   output logic                  overflow
);

   localparam logic [ADDR_LEN:0] FULL_CNT = (ADDR_LEN+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_LEN-1:0]   wptr_q, wptr_d;
   logic [ADDR_LEN-1:0]   rptr_q, rptr_d;
   logic [ADDR_LEN:0]     count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  push, pop;

   // Status decodes only from registered occupancy, never from inputs.
   assign outbuf_full = (count_q == FULL_CNT);
   assign out_valid   = (count_q != '0);
   assign count       = count_q;
   assign overflow    = overflow_q;
   assign dout        = out_valid ? mem_q[rptr_q] : '0;

   // A write while full is still accepted if the head leaves in the same cycle.
   assign pop  = out_valid & out_ready;
   assign push = outbuf_write & (~outbuf_full | pop);

   always_comb begin
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (flush) begin
         wptr_d     = '0;
         rptr_d     = '0;
         count_d    = '0;
         overflow_d = 1'b0;
      end else begin
         if (push) wptr_d = wptr_q + ADDR_LEN'(1);
         if (pop)  rptr_d = rptr_q + ADDR_LEN'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_LEN+1)'(1);
            2'b01:   count_d = count_q - (ADDR_LEN+1)'(1);
            default: count_d = count_q;
         endcase
         if (outbuf_write && !push) overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is not reset; the empty mask on dout hides stale contents.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wptr_q] <= din;
   end

endmodule
